// File: rtl/multi_pkg.sv
// Shared types and default constants for the multi-cycle start/done initiator.
package multi_pkg;

  localparam int MULTI_WIDTH   = 32;
  localparam int MULTI_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    RESP
  } multi_state_t;

endpackage

// File: rtl/multi_initiator_if.sv
// Request, device and response signals of multi_initiator. The initiator uses
// the master modport; the producer/device/consumer side uses the slave modport.
interface multi_initiator_if #(
  parameter int WIDTH = multi_pkg::MULTI_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic             dev_start;
  logic [WIDTH-1:0] dev_in;
  logic             dev_done;
  logic [WIDTH-1:0] dev_out;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_timeout;

  modport master (
    input  req_valid, req_data, dev_done, dev_out, resp_ready,
    output req_ready, dev_start, dev_in, resp_valid, resp_data, resp_timeout
  );

  modport slave (
    output req_valid, req_data, dev_done, dev_out, resp_ready,
    input  req_ready, dev_start, dev_in, resp_valid, resp_data, resp_timeout
  );

endinterface

// File: rtl/multi_initiator.sv
// Single-issue initiator: request -> one-cycle dev_start -> wait for dev_done -> response.
// Optional WAIT watchdog is compiled in with `define MULTI_INITIATOR_TIMEOUT_EN.
module multi_initiator
  import multi_pkg::*;
#(
  parameter int WIDTH   = MULTI_WIDTH,
  parameter int TIMEOUT = MULTI_TIMEOUT
) (
  input logic              clock,
  input logic              reset,
  multi_initiator_if.master bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("multi_initiator: TIMEOUT must be at least 1");
  end

  multi_state_t     state_q, state_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [WIDTH-1:0] result_q, result_d;

`ifdef MULTI_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      operand_q <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      result_q  <= result_d;
    end
  end

  // NOTE: every _d signal gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    result_d  = result_q;
`ifdef MULTI_INITIATOR_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          operand_d = bus.req_data;
          state_d   = START;
        end
      end
      START: begin
`ifdef MULTI_INITIATOR_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.dev_done) begin
          result_d = bus.dev_out;
`ifdef MULTI_INITIATOR_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef MULTI_INITIATOR_TIMEOUT_EN
        // The counter leaves WAIT on reaching TIMEOUT, so it can never wrap.
        else if (cnt_q == CNT_W'(TIMEOUT)) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.dev_start  = (state_q == START);
  assign bus.dev_in     = operand_q;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = result_q;
`ifdef MULTI_INITIATOR_TIMEOUT_EN
  assign bus.resp_timeout = timeout_q;
`else
  assign bus.resp_timeout = 1'b0;
`endif

endmodule

// File: doc/multi_initiator.md
# multi_initiator

Initiator for the single-issue multi-cycle start/done interface used by the team's multi-cycle compute blocks. It accepts a request word over a valid/ready handshake, issues a one-cycle `dev_start` with the operand, then waits for `dev_done` and captures `dev_out`. The result is returned over a second valid/ready handshake. It sits between an upstream producer and one multi-cycle device and guarantees at most one operation in flight.

## Interface
- `WIDTH`, 32: operand and result width.
- `TIMEOUT`, 15: maximum number of WAIT cycles before abort; only used with the watchdog compiled in; must be ≥1.
- `clock`  in  1  the single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  an upstream request is present.
- `req_ready`  out  1  the block can accept a request.
- `req_data`  in  WIDTH  request operand.
- `dev_start`  out  1  one-cycle start pulse to the device.
- `dev_in`  out  WIDTH  operand to the device; held stable from capture until the next capture.
- `dev_done`  in  1  device result valid.
- `dev_out`  in  WIDTH  device result.
- `resp_valid`  out  1  a response is present.
- `resp_ready`  in  1  downstream accepts the response.
- `resp_data`  out  WIDTH  captured result.
- `resp_timeout`  out  1  the response is an abort; qualified by `resp_valid`.

## Operation
- FSM states are IDLE, START, WAIT and RESP. Reset forces IDLE.
- IDLE:
  - `req_ready`=1.
  - When `req_valid` is high, latch `req_data` into the operand register and go to START.
- START:
  - `dev_start`=1 for exactly this cycle.
  - Clear the wait counter and go to WAIT.
  - `dev_done` is ignored in this cycle.
- WAIT:
  - If `dev_done` is high, latch `dev_out` into the result register, clear the timeout flag and go to RESP.
  - Otherwise increment the wait counter.
- RESP:
  - `resp_valid`=1, `resp_data` shows the result register, `resp_timeout` shows the flag.
  - When `resp_ready` is high, go to IDLE.
- `dev_done` in IDLE, START or RESP is ignored. No state change occurs and no data is captured.
- `req_ready` is 0 in every state except IDLE, so there is no request queuing.
- The wait counter is `$clog2(TIMEOUT+1)` bits wide and saturates; it never wraps.
- Reset mid-operation:
  - The FSM returns to IDLE and the operand, result, counter and flag registers are cleared.
  - Any in-flight device result is discarded, and a later `dev_done` is ignored because the FSM is in IDLE.
- Output values while in reset and after reset:
  - `req_ready`=1 (IDLE).
  - `dev_start`=0, `dev_in`=0.
  - `resp_valid`=0, `resp_data`=0, `resp_timeout`=0.

## Timing
- Request accepted at edge N: `dev_start` is high in cycle N+1 and WAIT begins in cycle N+2.
- `dev_done` sampled high in WAIT at edge M: `resp_valid` is high from cycle M+1.
- The response is accepted on the edge where `resp_valid`&`resp_ready` are both high. `req_ready` is high in the following cycle.
- Minimum turnaround from request handshake to next `req_ready` is 4 cycles, with `dev_done` on the first WAIT cycle and `resp_ready` held high.
- `resp_data` and `resp_timeout` are register outputs, stable for the whole RESP interval.
- `dev_start` is a decoded FSM output; it never stays high for two consecutive cycles.

## Configuration
- `MULTI_INITIATOR_TIMEOUT_EN` defined:
  - In WAIT, if `dev_done` is low and the counter equals `TIMEOUT`, go to RESP with the result register cleared to 0 and `resp_timeout`=1.
  - `dev_done` in that same cycle wins over the timeout.
- Not defined:
  - WAIT lasts until `dev_done`.
  - `resp_timeout` is tied to 0, and the counter and flag logic are removed.
  - The port list is identical in both builds.

## Structure
- Shared package `multi_pkg` holds:
  - the state enum `multi_state_t` (IDLE, START, WAIT, RESP);
  - the default width constant `MULTI_WIDTH`=32;
  - the default timeout constant `MULTI_TIMEOUT`=15.
- No sub-module: FSM, operand register, result register and counter fit in one module.
- The test bench pairs this block with the existing multi-cycle device, delay 1, as the device model.

## Test plan
- Single transaction:
  - Stimulus: `req_data`=0xDEADBEEF; device asserts `dev_done` with `dev_out`=0xDEADBEEF 2 cycles after `dev_start`; `resp_ready`=1.
  - Response: one `dev_start` pulse, `dev_in`=0xDEADBEEF, `resp_data`=0xDEADBEEF, `resp_timeout`=0, `req_ready` back after the response handshake.
- Backpressure:
  - Stimulus: `resp_ready` held low for 5 cycles.
  - Response: `resp_valid` stays high with `resp_data` unchanged; `req_ready`=0 throughout; a new `req_valid` is not accepted.
- Spurious done:
  - Stimulus: `dev_done`=1 with `dev_out`=0x1234 while in IDLE and in the START cycle.
  - Response: no state change and no capture; the later real done with 0x5678 yields `resp_data`=0x5678.
- Timeout, with `MULTI_INITIATOR_TIMEOUT_EN` defined and `TIMEOUT`=4:
  - Stimulus: the device never asserts done.
  - Response: `resp_valid` in the cycle after the 5th WAIT cycle, with `resp_data`=0 and `resp_timeout`=1.
- Reset mid-WAIT:
  - Stimulus: assert `reset` asynchronously 1 cycle after `dev_start`, then assert `dev_done` after release.
  - Response: outputs go to reset values immediately; no response is produced; `req_ready`=1.
- Back-to-back:
  - Stimulus: 3 requests 0x1, 0x2, 0x3 with `req_valid` continuously high and an echo device model.
  - Response: exactly 3 `dev_start` pulses and responses 0x1, 0x2, 0x3 in order.
